imem_loader: RTL

Boot-time instruction-memory writer for the 5-stage RISC-V pipeline. During fetch the core only reads instruction memory; this block fills it. It takes a length-prefixed byte stream over a valid/ready handshake and packs the bytes little-endian into 32-bit instructions. It writes them to consecutive word-aligned addresses through the instruction memory's write port, and holds the core in reset until the image is complete.

---
 rtl/imem_loader_pkg.sv | 45 ++++
 rtl/imem_loader_if.sv | 22 ++
 rtl/imem_byte_packer.sv | 27 ++
 rtl/imem_loader.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
package imem_loader_pkg;

    localparam int LEN_BYTES  = 2;
    localparam int WORD_BYTES = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LEN0  = 3'd1,
        LEN1  = 3'd2,
        DATA  = 3'd3,
        WRITE = 3'd4,
        DONE  = 3'd5,
        ERROR = 3'd6
    } state_t;

    typedef struct packed {
        logic byte_ready;
        logic busy;
        logic done;
        logic error;
        logic core_reset;
    } flags_t;

    // Status flags that hold for the whole time the FSM sits in a state.
    function automatic flags_t flags_of(input state_t s);
        flags_t f;
        f = '{byte_ready: 1'b0, busy: 1'b0, done: 1'b0, error: 1'b0, core_reset: 1'b1};
        case (s)
            LEN0, LEN1, DATA: begin
                f.byte_ready = 1'b1;
                f.busy       = 1'b1;
            end
            WRITE: f.busy = 1'b1;
            DONE: begin
                f.done       = 1'b1;
                f.core_reset = 1'b0;
            end
            ERROR:   f.error = 1'b1;
            default: f = f;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// A byte transfers on a rising edge where byte_valid and byte_ready are both 1;
// byte_ready comes from registered state only, and the producer holds byte_in
// stable while byte_valid=1 until that edge.
interface imem_loader_if;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        wr_en;
    logic [63:0] wr_addr;
    logic [31:0] wr_data;

    modport master (
        output byte_in, byte_valid,
        input  byte_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  byte_in, byte_valid,
        output byte_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/imem_byte_packer.sv
// Four-lane little-endian word assembler; the lane counter picks the byte slot.
module imem_byte_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        shift_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word_out,
    output logic        full
);
    logic [1:0] lane;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            lane     <= 2'd0;
            word_out <= 32'h0;
            full     <= 1'b0;
        end else if (shift_en) begin
            word_out[{lane, 3'b000} +: 8] <= byte_in;
            lane                          <= lane + 2'd1;
            full                          <= (lane == 2'(WORD_BYTES - 1));
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses a length-prefixed byte stream, writes packed words into
// instruction memory and keeps the core in reset until the image is complete.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    imem_loader_if.slave bus,
    output logic         core_reset,
    output logic         busy,
    output logic         done,
    output logic         error,
    output state_t       fsm_state
);
    localparam int HDR_BITS = 8 * LEN_BYTES;
    // Limit is one wider than the header so a full-capacity image is legal.
    localparam logic [HDR_BITS:0] MAX_WORDS = {{HDR_BITS{1'b0}}, 1'b1} << ADDR_W;

    state_t              state;
    flags_t              flags;
    logic [7:0]          len_lo;
    logic [HDR_BITS-1:0] len;
    logic [ADDR_W-1:0]   word_idx;
    logic [1:0]          byte_cnt;
    logic                wr_en;
    logic [63:0]         wr_addr;
    logic [31:0]         wr_data;

    logic                accept;
    logic [HDR_BITS-1:0] len_new;
    logic                len_bad;
    logic                last_word;
    logic                pack_clear;
    logic                pack_shift;
    logic [31:0]         pack_word;
    logic                pack_full;

    assign accept    = bus.byte_valid && flags.byte_ready;
    assign len_new   = {bus.byte_in, len_lo};
    assign len_bad   = (len_new == '0) || ({1'b0, len_new} > MAX_WORDS);
    assign last_word = ({{(HDR_BITS + 1 - ADDR_W){1'b0}}, word_idx}
                        == ({1'b0, len} - {{HDR_BITS{1'b0}}, 1'b1}));

    // Each word starts from an empty assembly register.
    assign pack_clear = ((state == LEN1) && accept) || ((state == WRITE) && pack_full);
    assign pack_shift = (state == DATA) && accept;

    imem_byte_packer u_packer (
        .clk      (clk),
        .reset    (reset),
        .clear    (pack_clear),
        .shift_en (pack_shift),
        .byte_in  (bus.byte_in),
        .word_out (pack_word),
        .full     (pack_full)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            flags    <= flags_of(IDLE);
            len_lo   <= 8'h0;
            len      <= '0;
            word_idx <= '0;
            byte_cnt <= 2'd0;
            wr_en    <= 1'b0;
            wr_addr  <= 64'h0;
            wr_data  <= 32'h0;
        end else begin
            wr_en <= 1'b0;
            case (state)
                IDLE, DONE, ERROR: begin
                    if (start) begin
                        state <= LEN0;
                        flags <= flags_of(LEN0);
                    end
                end
                LEN0: begin
                    if (accept) begin
                        len_lo <= bus.byte_in;
                        state  <= LEN1;
                        flags  <= flags_of(LEN1);
                    end
                end
                LEN1: begin
                    if (accept) begin
                        len <= len_new;
                        if (len_bad) begin
                            state <= ERROR;
                            flags <= flags_of(ERROR);
                        end else begin
                            word_idx <= '0;
                            byte_cnt <= 2'd0;
                            state    <= DATA;
                            flags    <= flags_of(DATA);
                        end
                    end
                end
                DATA: begin
                    if (accept) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'(WORD_BYTES - 1)) begin
                            // Top lane comes straight from the stream; the packer
                            // only sees it on this same edge.
                            wr_en   <= 1'b1;
                            wr_addr <= {{(62 - ADDR_W){1'b0}}, word_idx, 2'b00};
                            wr_data <= (pack_word & 32'h00FF_FFFF) | {bus.byte_in, 24'h000000};
                            state   <= WRITE;
                            flags   <= flags_of(WRITE);
                        end
                    end
                end
                WRITE: begin
                    if (last_word) begin
                        state <= DONE;
                        flags <= flags_of(DONE);
                    end else begin
                        word_idx <= word_idx + 1'b1;
                        state    <= DATA;
                        flags    <= flags_of(DATA);
                    end
                end
                default: begin
                    state <= IDLE;
                    flags <= flags_of(IDLE);
                end
            endcase
        end
    end

    assign bus.byte_ready = flags.byte_ready;
    assign bus.wr_en      = wr_en;
    assign bus.wr_addr    = wr_addr;
    assign bus.wr_data    = wr_data;
    assign core_reset     = flags.core_reset;
    assign busy           = flags.busy;
    assign done           = flags.done;
    assign error          = flags.error;
    assign fsm_state      = state;

endmodule
